// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_io_responder
//  Purpose  : Data-memory responder for the MIPS core. Serves word reads and
//             writes from a word RAM and a small MMIO bank that holds a
//             compare timer, a debounced push-button, an LED register and
//             the interrupt pending/enable logic. Reads are combinational,
//             so the core never stalls.
//  Ports    : clk, rst (async, active-high)
//             mem_ren/mem_wen/mem_addr/mem_dout : core request
//             mem_din     : read data (0 when mem_ren=0)
//             btn_in      : raw asynchronous push-button
//             interrupter : level interrupt to the core
//             led         : LED register contents
//  Revision : 1.0 - initial release
// ============================================================================
module mem_io_responder #(
    parameter int RAM_ADDR_W = 10,
    parameter int DEBOUNCE   = 16,
    parameter int LED_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_ren,
    input  logic             mem_wen,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_dout,
    output logic [31:0]      mem_din,
    input  logic             btn_in,
    output logic             interrupter,
    output logic [LED_W-1:0] led
);
    localparam int                c_DB_W      = $clog2(DEBOUNCE);
    localparam logic [c_DB_W-1:0] c_DB_LAST   = c_DB_W'(DEBOUNCE - 1);
    localparam logic [31:0]       c_ADDR_STAT = 32'hFFFF_0000;
    localparam logic [31:0]       c_ADDR_CTRL = 32'hFFFF_0004;
    localparam logic [31:0]       c_ADDR_CNT  = 32'hFFFF_0008;
    localparam logic [31:0]       c_ADDR_CMP  = 32'hFFFF_000C;
    localparam logic [31:0]       c_ADDR_LED  = 32'hFFFF_0010;

    // Storage
    logic [31:0]       r_ram [2**RAM_ADDR_W];
    logic [1:0]        r_pending;   // [0] btn_pending, [1] timer_pending
    logic [3:0]        r_ctrl;      // [0] btn_ie, [1] timer_ie, [2] timer_en, [3] autoreload
    logic [31:0]       r_cnt;
    logic [31:0]       r_cmp;
    logic [LED_W-1:0]  r_led;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_btn_level;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              r_irq;

    // Decode
    logic [31:0]           w_word;
    logic                  w_is_ram;
    logic [RAM_ADDR_W-1:0] w_ram_idx;
    logic                  w_wr_stat;
    logic                  w_wr_ctrl;
    logic                  w_wr_cnt;
    logic                  w_wr_cmp;
    logic                  w_wr_led;
    logic                  w_timer_hit;
    logic                  w_db_done;
    logic                  w_btn_rise;
    logic                  w_unused_lsb;

    // Byte-offset bits carry no meaning for word accesses.
    assign w_unused_lsb = ^mem_addr[1:0];

    assign w_word    = {mem_addr[31:2], 2'b00};
    assign w_is_ram  = (mem_addr[31:28] == 4'h0);
    assign w_ram_idx = mem_addr[RAM_ADDR_W+1:2];

    // MMIO addresses live in the 0xF region, so they never collide with RAM.
    assign w_wr_stat = mem_wen && (w_word == c_ADDR_STAT);
    assign w_wr_ctrl = mem_wen && (w_word == c_ADDR_CTRL);
    assign w_wr_cnt  = mem_wen && (w_word == c_ADDR_CNT);
    assign w_wr_cmp  = mem_wen && (w_word == c_ADDR_CMP);
    assign w_wr_led  = mem_wen && (w_word == c_ADDR_LED);

    assign w_timer_hit = r_ctrl[2] && (r_cnt == r_cmp);
    assign w_db_done   = (r_sync2 != r_btn_level) && (r_db_cnt == c_DB_LAST);
    assign w_btn_rise  = w_db_done && r_sync2;

    // Combinational read path; returns pre-write values on read+write.
    always_comb begin
        mem_din = 32'h0;
        if (mem_ren) begin
            if (w_is_ram) begin
                mem_din = r_ram[w_ram_idx];
            end else begin
                case (w_word)
                    c_ADDR_STAT: mem_din = {29'h0, r_btn_level, r_pending};
                    c_ADDR_CTRL: mem_din = {28'h0, r_ctrl};
                    c_ADDR_CNT:  mem_din = r_cnt;
                    c_ADDR_CMP:  mem_din = r_cmp;
                    c_ADDR_LED:  mem_din = 32'(r_led);
                    default:     mem_din = 32'h0;
                endcase
            end
        end
    end

    // RAM has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_wen && w_is_ram) begin
            r_ram[w_ram_idx] <= mem_dout;
        end
    end

    // Control, LED and timer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl <= 4'h0;
            r_led  <= '0;
            r_cnt  <= 32'h0;
            r_cmp  <= 32'hFFFF_FFFF;
        end else begin
            if (w_wr_ctrl) r_ctrl <= mem_dout[3:0];
            if (w_wr_led)  r_led  <= mem_dout[LED_W-1:0];
            if (w_wr_cmp)  r_cmp  <= mem_dout;
            // A core write beats both reload and increment.
            if (w_wr_cnt) begin
                r_cnt <= mem_dout;
            end else if (w_timer_hit && r_ctrl[3]) begin
                r_cnt <= 32'h0;
            end else if (r_ctrl[2]) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    // Pending bits: a set event in the same cycle as W1C keeps the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 2'b00;
        end else begin
            if (w_btn_rise) begin
                r_pending[0] <= 1'b1;
            end else if (w_wr_stat && mem_dout[0]) begin
                r_pending[0] <= 1'b0;
            end
            if (w_timer_hit) begin
                r_pending[1] <= 1'b1;
            end else if (w_wr_stat && mem_dout[1]) begin
                r_pending[1] <= 1'b0;
            end
        end
    end

    // Button synchronizer and debounce: the level follows the synchronized
    // input only after it has differed for DEBOUNCE consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_btn_level <= 1'b0;
            r_db_cnt    <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_btn_level) begin
                r_db_cnt <= '0;
            end else if (w_db_done) begin
                r_btn_level <= r_sync2;
                r_db_cnt    <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_DB_W'(1);
            end
        end
    end

    // Registered interrupt request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_pending[0] & r_ctrl[0]) | (r_pending[1] & r_ctrl[1]);
        end
    end

    assign interrupter = r_irq;
    assign led         = r_led;

endmodule
`default_nettype wire
